// File: rtl/signed_div16x8_if.sv
// Operand/result handshake bundle for the 16/8 signed divider.
interface signed_div16x8_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        ovf;
    logic        dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dz
    );
endinterface

// File: rtl/signed_div16x8.sv
// Sequential signed divider: 16-bit dividend by 8-bit divisor,
// restoring shift-subtract on magnitudes, one bit per cycle.
module signed_div16x8 #(
    parameter int ITER = 16
) (
    input  logic              clk,
    input  logic              rst,
    signed_div16x8_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_dzp;
    logic [8:0]  r_dsr;
    logic [15:0] r_dq;
    logic [7:0]  r_rem;
    logic        r_out_valid;
    logic [7:0]  r_quot;
    logic [7:0]  r_remo;
    logic        r_ovf;
    logic        r_dz;

    logic        w_acc;
    logic [15:0] w_dvd_abs;
    logic [8:0]  w_dsr_abs;
    logic [8:0]  w_sh;
    logic        w_ge;
    logic [7:0]  w_sub;
    logic        w_ovf;
    logic [7:0]  w_qneg;
    logic [7:0]  w_rneg;

    assign bus.in_ready  = (r_state == S_IDLE) && !rst;
    assign bus.out_valid = r_out_valid;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remo;
    assign bus.ovf       = r_ovf;
    assign bus.dz        = r_dz;

    assign w_acc = bus.in_valid && bus.in_ready;

    // 16'h8000 is the correct unsigned magnitude of -32768
    assign w_dvd_abs = bus.dividend[15] ? 16'd0 - bus.dividend
                                        : bus.dividend;
    assign w_dsr_abs = bus.divisor[7]
                     ? 9'd0 - {bus.divisor[7], bus.divisor}
                     : {1'b0, bus.divisor};

    assign w_sh  = {r_rem, r_dq[15]};
    assign w_ge  = w_sh >= r_dsr;
    // true difference is below 128, so 8-bit wraparound is exact
    assign w_sub = w_sh[7:0] - r_dsr[7:0];

    assign w_ovf  = r_sign_q ? (r_dq > 16'd128) : (r_dq > 16'd127);
    assign w_qneg = 8'd0 - r_dq[7:0];
    assign w_rneg = 8'd0 - r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dzp       <= 1'b0;
            r_dsr       <= '0;
            r_dq        <= '0;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_remo      <= '0;
            r_ovf       <= 1'b0;
            r_dz        <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_sign_q <= bus.dividend[15] ^ bus.divisor[7];
                        r_sign_r <= bus.dividend[15];
                        r_dsr    <= w_dsr_abs;
                        r_dq     <= w_dvd_abs;
                        r_rem    <= '0;
                        r_ovf    <= 1'b0;
                        r_dz     <= 1'b0;
                        r_dzp    <= (bus.divisor == 8'd0);
                        // zero divisor makes one dummy pass through CALC
                        r_cnt    <= (bus.divisor == 8'd0)
                                  ? 4'(ITER - 1) : 4'd0;
                        r_state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem <= w_ge ? w_sub : w_sh[7:0];
                    r_dq  <= {r_dq[14:0], w_ge};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'(ITER - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                    if (r_dzp) begin
                        r_dz   <= 1'b1;
                        r_ovf  <= 1'b0;
                        r_quot <= '0;
                        r_remo <= '0;
                    end else if (w_ovf) begin
                        r_ovf  <= 1'b1;
                        r_quot <= r_sign_q ? 8'h80 : 8'h7F;
                        r_remo <= '0;
                    end else begin
                        r_ovf  <= 1'b0;
                        r_quot <= r_sign_q ? w_qneg : r_dq[7:0];
                        r_remo <= r_sign_r ? w_rneg : r_rem;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
